// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline stage built as a DEPTH-entry circular buffer with valid/ready
// handshakes on both sides, a synchronous flush and saturating debug counters.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module if_id_skid_buffer #(
  parameter int                 NB_DATA  = 32,
  parameter int                 NB_ADDR  = `ADDRWIDTH,
  parameter int                 DEPTH    = 2,
  parameter logic [NB_DATA-1:0] NOP_INST = 32'hF8000000,
  parameter int                 NB_CNT   = 16
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       if_valid_i,
  input  logic [NB_ADDR-1:0]         if_pc_i,
  input  logic [NB_DATA-1:0]         if_instruction_i,
  output logic                       if_ready_o,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [NB_ADDR-1:0]         id_pc_o,
  output logic [NB_DATA-1:0]         id_instruction_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [NB_CNT-1:0]          flush_count_o,
  output logic [NB_CNT-1:0]          stall_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [NB_ADDR-1:0] pc_mem   [DEPTH];
  logic [NB_DATA-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [NB_CNT-1:0] flush_count;
  logic [NB_CNT-1:0] stall_count;

  logic push;
  logic pop;
  logic stall;

  // Ready depends only on the registered count, so an ID stall never ripples into IF.
  assign if_ready_o    = (count < CNT_W'(DEPTH));
  assign id_valid_o    = (count != '0);
  assign occupancy_o   = count;
  assign flush_count_o = flush_count;
  assign stall_count_o = stall_count;

  assign push  = if_valid_i & if_ready_o & ~flush_i;
  assign pop   = id_valid_o & id_ready_i & ~flush_i;
  assign stall = id_valid_o & ~id_ready_i & ~flush_i;

  always_comb begin
    id_pc_o          = '0;
    id_instruction_o = NOP_INST;
    if (id_valid_o) begin
      id_pc_o          = pc_mem[rd_ptr];
      id_instruction_o = inst_mem[rd_ptr];
    end
  end

  // Storage is deliberately left unreset; count and pointers alone define validity.
  always_ff @(posedge clock_i) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc_i;
      inst_mem[wr_ptr] <= if_instruction_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      flush_count <= '0;
      stall_count <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (flush_count != '1) begin
        flush_count <= flush_count + NB_CNT'(1);
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + NB_CNT'(1);
      end
    end
  end

endmodule

// File: doc/if_id_skid_buffer.md
# if_id_skid_buffer

Parametrised IF/ID pipeline stage that replaces the single-entry IF/ID register with a DEPTH-entry circular buffer. Fetch and decode are connected by valid/ready handshakes, so an ID stall no longer forces a combinational stall back into IF. A synchronous flush (jump/branch taken) discards every buffered entry and presents a programmable NOP bubble to ID. Saturating flush and stall counters are exported for the debug unit.

## Interface
- NB_DATA, 32, instruction width
- NB_ADDR, `ADDRWIDTH, PC width
- DEPTH, 2, buffer entries; power of two, ≥2
- NOP_INST, 32'hF8000000, word driven on id_instruction_o when the buffer is empty
- NB_CNT, 16, width of the debug counters
- clock_i  in  1  processor clock; all state updates on the rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  jump_or_branch taken; kills all entries this cycle
- if_valid_i  in  1  IF presents an instruction
- if_pc_i  in  NB_ADDR  PC of the IF instruction
- if_instruction_i  in  NB_DATA  fetched word
- if_ready_o  out  1  buffer can accept an entry
- id_ready_i  in  1  ID consumes the head entry
- id_valid_o  out  1  head entry is valid
- id_pc_o  out  NB_ADDR  head PC; 0 when empty
- id_instruction_o  out  NB_DATA  head word; NOP_INST when empty
- occupancy_o  out  $clog2(DEPTH+1)  number of valid entries
- flush_count_o  out  NB_CNT  flushes seen; saturating
- stall_count_o  out  NB_CNT  cycles with id_valid_o=1 and id_ready_i=0; saturating

## Operation
- Storage: DEPTH × {pc, instruction} array, with wr_ptr and rd_ptr of width $clog2(DEPTH) that wrap modulo DEPTH, plus a count register.
- if_ready_o = (count < DEPTH). It is decoded from registers only and has no combinational path from id_ready_i.
- id_valid_o = (count != 0). id_pc_o and id_instruction_o are driven from array[rd_ptr] when valid, else 0 and NOP_INST.
- push = if_valid_i & if_ready_o & ~flush_i. On push: write array[wr_ptr], then wr_ptr+1.
- pop = id_valid_o & id_ready_i & ~flush_i. On pop: rd_ptr+1.
- count update: push only → +1; pop only → −1; push and pop → unchanged; neither → unchanged.
- Flush (flush_i=1) has the highest priority:
  - wr_ptr, rd_ptr and count are set to 0.
  - Any offered IF entry is dropped and any ID handshake is ignored.
  - flush_count increments, saturating at 2^NB_CNT−1.
- Stall count: increments when id_valid_o & ~id_ready_i & ~flush_i, saturating.
- Entries are never overwritten while valid and never read while invalid. Overflow and underflow cannot occur by construction.
- Array contents are not reset; only the pointers, count and counters are.

## Timing
- Reset (async assert, sync-safe deassert handled upstream) drives:
  - count=0, pointers=0, if_ready_o=1, id_valid_o=0, id_pc_o=0
  - id_instruction_o=NOP_INST, occupancy_o=0, both counters=0
- Latency: an entry pushed at edge k is visible on id_* after edge k, i.e. 1 cycle.
- Throughput: 1 entry/cycle sustained when id_ready_i is held high (DEPTH≥2).
- Full (count=DEPTH): if_ready_o=0 for the whole cycle, even if ID pops in that cycle. It reasserts after the edge at which the pop occurs.
- Empty with a simultaneous push: no bypass. The entry appears next cycle.
- Flush together with push and pop: after the edge count=0 and nothing is retained. The next cycle shows id_valid_o=0 and id_instruction_o=NOP_INST.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no loss of ordering.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronous); buffered entries are lost.

## Test plan
- **Reset:** assert reset_n_i=0 mid-stream → immediately if_ready_o=1, id_valid_o=0, id_instruction_o=32'hF8000000, occupancy_o=0, counters=0.
- **Streaming:** 8 pushes with PCs 0x00..0x1C and id_ready_i=1 → id_pc_o follows 1 cycle behind with no bubbles; occupancy_o stays ≤1.
- **Fill and drain:**
  - id_ready_i=0 while pushing 3 entries, DEPTH=2 → after 2 pushes if_ready_o=0, the 3rd is held, and stall_count_o increments each stalled cycle.
  - Release id_ready_i → entries pop in order; if_ready_o returns 1 the cycle after the first pop.
- **Flush:** with 2 entries buffered and a push offered, assert flush_i for 1 cycle → next cycle id_valid_o=0, id_instruction_o=NOP_INST, occupancy_o=0, flush_count_o=1, and the offered entry never appears.
- **Wrap-around:** DEPTH=4, 11 interleaved push/pop operations with random id_ready_i → output order matches a scoreboard model; pointers wrap correctly.
- **Saturation:** NB_CNT=2, 5 flushes → flush_count_o stops at 3.
